pc_next_unit: RTL and testbench

Program-counter and control-flow resolution stage for the single-cycle RV32I core. It consumes the ALU's flags and result for the current instruction, decides whether a branch or jump is taken, and computes the next PC. It holds the architectural PC register, a retired-instruction counter, and a halt/trap state entered on a misaligned control-flow target. Instruction fetch and the register-file write-back mux (link value `pc_plus4`) read it.

---
 rtl/pc_next_unit_if.sv | 33 +++
 rtl/pc_next_unit.sv | 93 +++++++++
 tb/tb_pc_next_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_next_unit_if.sv
// Bundle of the per-instruction control-flow inputs and the PC/trap state outputs
// exchanged between the core datapath and pc_next_unit.
interface pc_next_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 en;
  logic                 branch;
  logic                 jal;
  logic                 jalr;
  logic [2:0]           funct3;
  logic [WIDTH-1:0]     imm;
  logic [WIDTH-1:0]     alu_result;
  logic                 zero;
  logic                 sltu;
  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     pc_plus4;
  logic [WIDTH-1:0]     next_pc;
  logic                 taken;
  logic                 halted;
  logic [WIDTH-1:0]     trap_pc;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    output en, branch, jal, jalr, funct3, imm, alu_result, zero, sltu,
    input  pc, pc_plus4, next_pc, taken, halted, trap_pc, instret
  );

  modport slave (
    input  en, branch, jal, jalr, funct3, imm, alu_result, zero, sltu,
    output pc, pc_plus4, next_pc, taken, halted, trap_pc, instret
  );
endinterface

// File: rtl/pc_next_unit.sv
// PC register, branch/jump resolution and next-PC selection for the single-cycle RV32I core,
// with a retired-instruction counter and a sticky halt on misaligned control-flow targets.
module pc_next_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               CNT_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_next_if.slave bus
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_pc;
  logic [WIDTH-1:0]     r_trap_pc;
  logic                 r_halted;
  logic [CNT_WIDTH-1:0] r_instret;

  logic                 w_cond;
  logic                 w_taken;
  logic                 w_misalign;
  logic [WIDTH-1:0]     w_pc_plus4;
  logic [WIDTH-1:0]     w_pc_rel;
  logic [WIDTH-1:0]     w_next_pc;

  // BLT/BGE see an SLT result, so zero=0 means "less than".
  always_comb begin
    w_cond = 1'b0;
    case (bus.funct3)
      3'b000:  w_cond = bus.zero;
      3'b001:  w_cond = ~bus.zero;
      3'b100:  w_cond = ~bus.zero;
      3'b101:  w_cond = bus.zero;
      3'b110:  w_cond = bus.sltu;
      3'b111:  w_cond = ~bus.sltu;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_plus4 = r_pc + WIDTH'(4);
  assign w_pc_rel   = r_pc + bus.imm;
  assign w_taken    = bus.jalr | bus.jal | (bus.branch & w_cond);

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (bus.jalr)
      w_next_pc = bus.alu_result & ~WIDTH'(1);
    else if (bus.jal || (bus.branch && w_cond))
      w_next_pc = w_pc_rel;
  end

  // Bit 0 is already cleared for JALR, so only bit 1 can fault.
  assign w_misalign = w_taken & w_next_pc[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_trap_pc <= '0;
      r_halted  <= 1'b0;
      r_instret <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.en) begin
            if (w_misalign) begin
              r_state   <= ST_HALT;
              r_halted  <= 1'b1;
              r_trap_pc <= r_pc;
            end else begin
              r_pc      <= w_next_pc;
              r_instret <= r_instret + CNT_WIDTH'(1);
            end
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.pc       = r_pc;
  assign bus.pc_plus4 = w_pc_plus4;
  assign bus.next_pc  = w_next_pc;
  assign bus.taken    = w_taken;
  assign bus.halted   = r_halted;
  assign bus.trap_pc  = r_trap_pc;
  assign bus.instret  = r_instret;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus randomized traffic
// against an architectural RV32I control-flow model.
module tb_pc_next_unit;
  localparam int          W   = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_next_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus();

  pc_next_unit #(.WIDTH(W), .RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0]   m_pc;
  logic [31:0]   m_trap_pc;
  logic [CW-1:0] m_instret;
  logic          m_halted;
  logic          m_truth;

  // Architectural meaning of each branch on its register operands.
  function automatic logic riscv_truth(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_taken();
    return bus.jalr | bus.jal | (bus.branch & m_truth);
  endfunction

  function automatic logic [31:0] m_target();
    if (bus.jalr) return bus.alu_result & 32'hFFFF_FFFE;
    if (bus.jal || (bus.branch && m_truth)) return m_pc + bus.imm;
    return m_pc + 32'd4;
  endfunction

  task automatic idle();
    bus.branch = 0; bus.jal = 0; bus.jalr = 0; bus.funct3 = 3'b000;
    bus.imm = '0; bus.alu_result = '0; bus.zero = 0; bus.sltu = 0;
    m_truth = 0;
  endtask

  // Emulates the ALU op the decoder selects for each branch kind.
  task automatic drive_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.branch = 1; bus.jal = 0; bus.jalr = 0; bus.funct3 = f3;
    bus.sltu = (a < b);
    case (f3[2:1])
      2'b00:   bus.zero = ((a - b) == 32'd0);
      2'b10:   bus.zero = !($signed(a) < $signed(b));
      default: bus.zero = 1'($urandom_range(0, 1));
    endcase
    m_truth = riscv_truth(f3, a, b);
  endtask

  task automatic cycle();
    logic [31:0] t;
    logic        tk;
    logic        rs;
    t  = m_target();
    tk = m_taken();
    rs = rst_n;
    @(posedge clk);
    #1;
    if (!rs) begin
      m_pc = RPC; m_trap_pc = '0; m_instret = '0; m_halted = 0;
    end else if (!m_halted && bus.en) begin
      if (tk && t[1]) begin
        m_halted = 1; m_trap_pc = m_pc;
      end else begin
        m_pc = t; m_instret = m_instret + 1'b1;
      end
    end
  endtask

  task automatic go_to(input logic [31:0] addr);
    idle(); bus.en = 1; bus.jalr = 1; bus.alu_result = addr;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 0; bus.en = 1; idle();
    cycle(); cycle();
    checks++; if (bus.pc !== 32'h100) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h100); end
    checks++; if (bus.instret !== 4'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", bus.instret); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.trap_pc !== 32'h0) begin failures++; $display("FAIL reset_trap_pc got=%h exp=0", bus.trap_pc); end
    rst_n = 1;
    for (int i = 0; i < 3; i++) cycle();
    checks++; if (bus.pc !== 32'h10C) begin failures++; $display("FAIL seq_pc got=%h exp=%h", bus.pc, 32'h10C); end
    checks++; if (bus.instret !== 4'd3) begin failures++; $display("FAIL seq_instret got=%0d exp=3", bus.instret); end
  endtask

  task automatic test_branches();
    logic [2:0]  f3 [7] = '{3'b000, 3'b001, 3'b110, 3'b111, 3'b100, 3'b101, 3'b010};
    logic [31:0] a  [7] = '{32'd5, 32'd5, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] b  [7] = '{32'd5, 32'd5, 32'd2, 32'd2, 32'd1, 32'd1, 32'd7};
    logic [31:0] ex [7] = '{32'h1F0, 32'h204, 32'h1F0, 32'h204, 32'h1F0, 32'h204, 32'h204};
    for (int i = 0; i < 7; i++) begin
      go_to(32'h200);
      drive_branch(f3[i], a[i], b[i]);
      bus.imm = 32'hFFFF_FFF0;
      #1;
      checks++;
      if (bus.taken !== (ex[i] == 32'h1F0))
        begin failures++; $display("FAIL br_taken f3=%b got=%b exp=%b", f3[i], bus.taken, ex[i] == 32'h1F0); end
      cycle();
      checks++;
      if (bus.pc !== ex[i]) begin failures++; $display("FAIL br_pc f3=%b got=%h exp=%h", f3[i], bus.pc, ex[i]); end
    end
    idle();
  endtask

  task automatic test_jumps();
    go_to(32'h300);
    bus.jalr = 1; bus.alu_result = 32'h0000_1235;
    cycle();
    checks++; if (bus.pc !== 32'h1234) begin failures++; $display("FAIL jalr_pc got=%h exp=%h", bus.pc, 32'h1234); end
    idle(); bus.jalr = 1; bus.jal = 1; bus.alu_result = 32'h2001; bus.imm = 32'h40;
    cycle();
    checks++; if (bus.pc !== 32'h2000) begin failures++; $display("FAIL jal_jalr_prio got=%h exp=%h", bus.pc, 32'h2000); end
    go_to(32'h10);
    bus.jal = 1; bus.imm = 32'h20;
    #1;
    checks++; if (bus.pc_plus4 !== 32'h14) begin failures++; $display("FAIL jal_link got=%h exp=%h", bus.pc_plus4, 32'h14); end
    checks++; if (bus.next_pc !== 32'h30) begin failures++; $display("FAIL jal_next got=%h exp=%h", bus.next_pc, 32'h30); end
    cycle();
    checks++; if (bus.pc !== 32'h30) begin failures++; $display("FAIL jal_pc got=%h exp=%h", bus.pc, 32'h30); end
    idle();
  endtask

  task automatic test_trap();
    logic [CW-1:0] cnt;
    go_to(32'h40);
    cnt = bus.instret;
    bus.jal = 1; bus.imm = 32'h6;
    #1;
    checks++; if (bus.next_pc !== 32'h46) begin failures++; $display("FAIL trap_next got=%h exp=%h", bus.next_pc, 32'h46); end
    cycle();
    checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL trap_halted got=%b exp=1", bus.halted); end
    checks++; if (bus.trap_pc !== 32'h40) begin failures++; $display("FAIL trap_pc got=%h exp=%h", bus.trap_pc, 32'h40); end
    checks++; if (bus.pc !== 32'h40) begin failures++; $display("FAIL trap_pc_held got=%h exp=%h", bus.pc, 32'h40); end
    checks++; if (bus.instret !== cnt) begin failures++; $display("FAIL trap_instret got=%0d exp=%0d", bus.instret, cnt); end
    idle(); bus.jalr = 1; bus.alu_result = 32'h800;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (bus.pc !== 32'h40 || bus.halted !== 1'b1 || bus.instret !== cnt || bus.trap_pc !== 32'h40)
      begin failures++; $display("FAIL halt_hold got pc=%h halted=%b instret=%0d exp pc=40 halted=1 instret=%0d", bus.pc, bus.halted, bus.instret, cnt); end
    idle(); rst_n = 0;
    cycle();
    rst_n = 1;
    checks++;
    if (bus.pc !== RPC || bus.halted !== 1'b0 || bus.trap_pc !== 32'h0)
      begin failures++; $display("FAIL halt_reset got pc=%h halted=%b trap_pc=%h exp pc=%h halted=0 trap_pc=0", bus.pc, bus.halted, bus.trap_pc, RPC); end
  endtask

  task automatic test_stall();
    logic [CW-1:0] cnt;
    go_to(32'h200);
    cnt = bus.instret;
    bus.en = 0;
    drive_branch(3'b000, 32'd9, 32'd9);
    bus.imm = 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) cycle();
    checks++; if (bus.pc !== 32'h200) begin failures++; $display("FAIL stall_pc got=%h exp=%h", bus.pc, 32'h200); end
    checks++; if (bus.instret !== cnt) begin failures++; $display("FAIL stall_instret got=%0d exp=%0d", bus.instret, cnt); end
    idle(); bus.jal = 1; bus.imm = 32'h6;
    cycle();
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL stall_misalign got=%b exp=0", bus.halted); end
    idle(); bus.en = 1;
  endtask

  task automatic test_wrap();
    go_to(32'hFFFF_FFFC);
    #1;
    checks++; if (bus.pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_plus4 got=%h exp=0", bus.pc_plus4); end
    cycle();
    checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", bus.pc); end
    rst_n = 0; cycle(); rst_n = 1;
    for (int i = 0; i < 15; i++) cycle();
    checks++; if (bus.instret !== 4'hF) begin failures++; $display("FAIL cnt_full got=%0d exp=15", bus.instret); end
    cycle();
    checks++; if (bus.instret !== 4'h0) begin failures++; $display("FAIL cnt_wrap got=%0d exp=0", bus.instret); end
  endtask

  task automatic test_random();
    int kind;
    for (int i = 0; i < 400; i++) begin
      idle();
      rst_n  = ($urandom_range(0, 14) != 0);
      bus.en = ($urandom_range(0, 3) != 0);
      kind   = $urandom_range(0, 3);
      bus.imm        = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
      bus.alu_result = 32'($urandom);
      if (kind == 1) drive_branch(3'($urandom_range(0, 7)), 32'($urandom), ($urandom_range(0, 3) == 0) ? 32'($urandom) & 32'hF : 32'($urandom));
      if (kind == 2) bus.jal = 1;
      if (kind == 3) begin
        bus.jalr = 1;
        if ($urandom_range(0, 3) != 0) bus.alu_result[1] = 1'b0;
      end
      #1;
      checks++;
      if (bus.taken !== m_taken() || bus.next_pc !== m_target() || bus.pc_plus4 !== m_pc + 32'd4)
        begin failures++; $display("FAIL rnd_comb i=%0d got taken=%b next=%h p4=%h exp taken=%b next=%h p4=%h", i, bus.taken, bus.next_pc, bus.pc_plus4, m_taken(), m_target(), m_pc + 32'd4); end
      cycle();
      checks++;
      if (bus.pc !== m_pc || bus.halted !== m_halted || bus.trap_pc !== m_trap_pc || bus.instret !== m_instret)
        begin failures++; $display("FAIL rnd_state i=%0d got pc=%h h=%b tp=%h n=%0d exp pc=%h h=%b tp=%h n=%0d", i, bus.pc, bus.halted, bus.trap_pc, bus.instret, m_pc, m_halted, m_trap_pc, m_instret); end
    end
    rst_n = 1; idle();
  endtask

  initial begin
    rst_n = 0; bus.en = 0; idle();
    test_reset();
    test_branches();
    test_jumps();
    test_trap();
    test_stall();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
